// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS core's memory stage: store kinds, load kinds
// and the alignment rules that apply to each.
package mips_pkg;

  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_WORD = 2'b01,
    MW_HALF = 2'b10,
    MW_BYTE = 2'b11
  } memwrite_t;

  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LH  = 3'b001,
    LT_LHU = 3'b010,
    LT_LB  = 3'b011,
    LT_LBU = 3'b100
  } loadtype_t;

  function automatic logic store_misaligned(input memwrite_t mw, input logic [1:0] off);
    logic mis;
    case (mw)
      MW_WORD: mis = (off != 2'b00);
      MW_HALF: mis = off[0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Undefined load encodings behave as lw, so they inherit word alignment.
  function automatic logic load_misaligned(input loadtype_t lt, input logic [1:0] off);
    logic mis;
    case (lt)
      LT_LH, LT_LHU: mis = off[0];
      LT_LB, LT_LBU: mis = 1'b0;
      default:       mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_format.sv
// Big-endian lane select and sign/zero extension of a memory word for the
// load instructions; purely combinational.
module load_format
  import mips_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  loadtype,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte and halfword lanes addressed by the low address bits
  always_comb begin
    byte_s = 8'h00;
    case (offset)
      2'b00:   byte_s = word[31:24];
      2'b01:   byte_s = word[23:16];
      2'b10:   byte_s = word[15:8];
      2'b11:   byte_s = word[7:0];
      default: byte_s = 8'h00;
    endcase
    if (offset[1]) begin
      half_s = word[15:0];
    end else begin
      half_s = word[31:16];
    end
  end

  // Extension according to the load kind
  always_comb begin
    result = word;
    case (loadtype_t'(loadtype))
      LT_LH:   result = {{16{half_s[15]}}, half_s};
      LT_LHU:  result = {16'h0000, half_s};
      LT_LB:   result = {{24{byte_s[7]}}, byte_s};
      LT_LBU:  result = {24'h000000, byte_s};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: word-organised data memory with byte/half/word stores, load
// formatting and the MEM/WB pipeline register.
module mem_stage_lsu
  import mips_pkg::*;
#(
  parameter int    DEPTH     = 64,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  input  logic [1:0]  memwrite,
  input  logic        memread,
  input  logic [2:0]  loadtype,
  input  logic        regwrite_m,
  input  logic        memtoreg_m,
  input  logic [4:0]  writereg_m,
  input  logic        stall_w,
  input  logic        flush_w,
  output logic [31:0] readdata_w,
  output logic [31:0] aluout_w,
  output logic        regwrite_w,
  output logic        memtoreg_w,
  output logic [4:0]  writereg_w,
  output logic        misalign_w
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] idx_s;
  logic [1:0]    off_s;
  memwrite_t     mw_s;
  loadtype_t     lt_s;
  logic          st_mis_s;
  logic          ld_mis_s;
  logic          misalign_s;
  logic          store_en_s;
  logic [31:0]   rd_word_s;
  logic [31:0]   merged_s;
  logic [31:0]   fmt_s;
  logic [31:0]   readdata_s;

  // Upper address bits are dropped, so the word index wraps around the array.
  assign idx_s     = dataadr[AW+1:2];
  assign off_s     = dataadr[1:0];
  assign mw_s      = memwrite_t'(memwrite);
  assign lt_s      = loadtype_t'(loadtype);
  assign rd_word_s = mem_r[idx_s];

  // Alignment check and store enable
  always_comb begin
    st_mis_s   = store_misaligned(mw_s, off_s);
    ld_mis_s   = 1'b0;
    if (memread) begin
      ld_mis_s = load_misaligned(lt_s, off_s);
    end else begin
      ld_mis_s = 1'b0;
    end
    misalign_s = st_mis_s | ld_mis_s;
    store_en_s = (mw_s != MW_NONE) && !st_mis_s;
  end

  // Merge store data into the addressed lanes of the current word
  always_comb begin
    merged_s = rd_word_s;
    case (mw_s)
      MW_WORD: merged_s = writedata;
      MW_HALF: begin
        if (off_s[1]) begin
          merged_s[15:0] = writedata[15:0];
        end else begin
          merged_s[31:16] = writedata[15:0];
        end
      end
      MW_BYTE: begin
        case (off_s)
          2'b00:   merged_s[31:24] = writedata[7:0];
          2'b01:   merged_s[23:16] = writedata[7:0];
          2'b10:   merged_s[15:8]  = writedata[7:0];
          2'b11:   merged_s[7:0]   = writedata[7:0];
          default: merged_s        = rd_word_s;
        endcase
      end
      default: merged_s = rd_word_s;
    endcase
  end

  // Data array write; deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (store_en_s) begin
      mem_r[idx_s] <= merged_s;
    end
  end

  load_format u_load_format (
    .word     (rd_word_s),
    .offset   (off_s),
    .loadtype (loadtype),
    .result   (fmt_s)
  );

  // Load result is squashed when no load is present or it is misaligned
  always_comb begin
    if (memread && !ld_mis_s) begin
      readdata_s = fmt_s;
    end else begin
      readdata_s = 32'h0000_0000;
    end
  end

  // MEM/WB pipeline register: reset > flush > stall > capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_w <= 32'h0000_0000;
      aluout_w   <= 32'h0000_0000;
      regwrite_w <= 1'b0;
      memtoreg_w <= 1'b0;
      writereg_w <= 5'd0;
      misalign_w <= 1'b0;
    end else if (flush_w) begin
      readdata_w <= 32'h0000_0000;
      aluout_w   <= 32'h0000_0000;
      regwrite_w <= 1'b0;
      memtoreg_w <= 1'b0;
      writereg_w <= 5'd0;
      misalign_w <= 1'b0;
    end else if (!stall_w) begin
      readdata_w <= readdata_s;
      aluout_w   <= dataadr;
      regwrite_w <= regwrite_m & ~misalign_s;
      memtoreg_w <= memtoreg_m;
      writereg_w <= writereg_m;
      misalign_w <= misalign_s;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed vector table, stall/flush
// and async-reset sequences, then random traffic against a byte-level model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataadr, writedata;
  logic [1:0]  memwrite;
  logic        memread;
  logic [2:0]  loadtype;
  logic        regwrite_m, memtoreg_m;
  logic [4:0]  writereg_m;
  logic        stall_w, flush_w;
  logic [31:0] readdata_w, aluout_w;
  logic        regwrite_w, memtoreg_w, misalign_w;
  logic [4:0]  writereg_w;

  mem_stage_lsu #(.DEPTH(64), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .dataadr(dataadr), .writedata(writedata),
    .memwrite(memwrite), .memread(memread), .loadtype(loadtype),
    .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .writereg_m(writereg_m),
    .stall_w(stall_w), .flush_w(flush_w), .readdata_w(readdata_w),
    .aluout_w(aluout_w), .regwrite_w(regwrite_w), .memtoreg_w(memtoreg_w),
    .writereg_w(writereg_w), .misalign_w(misalign_w)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: byte-addressed memory image and expected MEM/WB contents
  logic [7:0]  mbytes [256];
  logic [31:0] e_rd, e_alu;
  logic        e_rw, e_mtr, e_mis;
  logic [4:0]  e_wr;

  typedef struct {
    logic [1:0]  mw;
    logic        mr;
    logic [2:0]  lt;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int ld_size(input logic [2:0] lt);
    case (lt)
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default:    return 4;
    endcase
  endfunction

  function automatic int st_size(input logic [1:0] mw);
    case (mw)
      2'd1:    return 4;
      2'd2:    return 2;
      2'd3:    return 1;
      default: return 0;
    endcase
  endfunction

  // Reference behaviour for one clock edge, evaluated on pre-edge state
  task automatic model_step();
    int a, ls, ss;
    logic [31:0] v, t;
    logic mis, st_ok;
    a  = int'(dataadr[7:0]);
    ls = ld_size(loadtype);
    ss = st_size(memwrite);
    st_ok = (ss != 0) && (a % ss == 0);
    mis = ((ss != 0) && (a % ss != 0)) || (memread && (a % ls != 0));
    v = 32'd0;
    if (memread && (a % ls == 0)) begin
      for (int i = 0; i < ls; i++) v = (v << 8) | {24'd0, mbytes[a + i]};
      if (loadtype == 3'd1) v = {{16{v[15]}}, v[15:0]};
      if (loadtype == 3'd3) v = {{24{v[7]}}, v[7:0]};
    end
    if (st_ok) begin
      for (int i = 0; i < ss; i++) begin
        t = writedata >> (8 * (ss - 1 - i));
        mbytes[a + i] = t[7:0];
      end
    end
    if (flush_w) begin
      e_rd = 32'd0; e_alu = 32'd0; e_rw = 1'b0; e_mtr = 1'b0; e_wr = 5'd0; e_mis = 1'b0;
    end else if (!stall_w) begin
      e_rd = v; e_alu = dataadr; e_rw = regwrite_m & ~mis; e_mtr = memtoreg_m;
      e_wr = writereg_m; e_mis = mis;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".readdata"}, readdata_w, e_rd);
    check({tag, ".aluout"},   aluout_w,   e_alu);
    check({tag, ".regwrite"}, {31'd0, regwrite_w}, {31'd0, e_rw});
    check({tag, ".memtoreg"}, {31'd0, memtoreg_w}, {31'd0, e_mtr});
    check({tag, ".writereg"}, {27'd0, writereg_w}, {27'd0, e_wr});
    check({tag, ".misalign"}, {31'd0, misalign_w}, {31'd0, e_mis});
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".readdata"}, readdata_w, 32'd0);
    check({tag, ".aluout"},   aluout_w,   32'd0);
    check({tag, ".ctrl"}, {26'd0, regwrite_w, memtoreg_w, writereg_w, misalign_w}, 32'd0);
  endtask

  task automatic set_in(input logic [1:0] mw, input logic mr, input logic [2:0] lt,
                        input logic [31:0] adr, input logic [31:0] wd, input logic [4:0] wr);
    memwrite = mw; memread = mr; loadtype = lt; dataadr = adr; writedata = wd;
    regwrite_m = 1'b1; memtoreg_m = mr; writereg_m = wr; stall_w = 1'b0; flush_w = 1'b0;
  endtask

  function automatic void add(input logic [1:0] mw, input logic mr, input logic [2:0] lt,
                              input logic [31:0] adr, input logic [31:0] wd,
                              input logic [31:0] rd, input logic mis);
    vecs.push_back('{mw, mr, lt, adr, wd, rd, mis});
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mbytes[i] = 8'h00;
    e_rd = 32'd0; e_alu = 32'd0; e_rw = 1'b0; e_mtr = 1'b0; e_wr = 5'd0; e_mis = 1'b0;

    // mw, mr, lt, adr, wd, expected readdata_w, expected misalign_w
    add(2'd3, 1'b0, 3'd0, 32'd80,        32'h0000_00FF, 32'h0000_0000, 1'b0);
    add(2'd0, 1'b1, 3'd4, 32'd80,        32'h0,         32'h0000_00FF, 1'b0);
    add(2'd0, 1'b1, 3'd3, 32'd80,        32'h0,         32'hFFFF_FFFF, 1'b0);
    add(2'd0, 1'b1, 3'd0, 32'd80,        32'h0,         32'hFF00_0000, 1'b0);
    add(2'd1, 1'b0, 3'd0, 32'd84,        32'h1234_5678, 32'h0000_0000, 1'b0);
    add(2'd0, 1'b1, 3'd1, 32'd86,        32'h0,         32'h0000_5678, 1'b0);
    add(2'd0, 1'b1, 3'd2, 32'd84,        32'h0,         32'h0000_1234, 1'b0);
    add(2'd0, 1'b1, 3'd3, 32'd85,        32'h0,         32'h0000_0034, 1'b0);
    add(2'd1, 1'b0, 3'd0, 32'd80,        32'h0,         32'h0000_0000, 1'b0);
    add(2'd2, 1'b0, 3'd0, 32'd82,        32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    add(2'd0, 1'b1, 3'd0, 32'd80,        32'h0,         32'h0000_BEEF, 1'b0);
    add(2'd0, 1'b1, 3'd1, 32'd82,        32'h0,         32'hFFFF_BEEF, 1'b0);
    add(2'd0, 1'b1, 3'd0, 32'hFFFF_0050, 32'h0,         32'h0000_BEEF, 1'b0);
    add(2'd1, 1'b0, 3'd0, 32'd81,        32'hAAAA_AAAA, 32'h0000_0000, 1'b1);
    add(2'd0, 1'b1, 3'd1, 32'd83,        32'h0,         32'h0000_0000, 1'b1);
    add(2'd0, 1'b1, 3'd0, 32'd80,        32'h0,         32'h0000_BEEF, 1'b0);
    add(2'd0, 1'b1, 3'd0, 32'd84,        32'h0,         32'h1234_5678, 1'b0);
    add(2'd1, 1'b1, 3'd0, 32'd88,        32'h1111_1111, 32'h0000_0000, 1'b0);
    add(2'd0, 1'b1, 3'd0, 32'd88,        32'h0,         32'h1111_1111, 1'b0);
    add(2'd3, 1'b0, 3'd0, 32'd87,        32'hABCD_EF5A, 32'h0000_0000, 1'b0);
    add(2'd0, 1'b1, 3'd0, 32'd84,        32'h0,         32'h1234_565A, 1'b0);
    add(2'd0, 1'b1, 3'd5, 32'd84,        32'h0,         32'h1234_565A, 1'b0);
    add(2'd0, 1'b0, 3'd0, 32'd84,        32'h0,         32'h0000_0000, 1'b0);
    add(2'd0, 1'b1, 3'd4, 32'd83,        32'h0,         32'h0000_00EF, 1'b0);
    add(2'd0, 1'b1, 3'd3, 32'd83,        32'h0,         32'hFFFF_FFEF, 1'b0);

    reset = 1'b1;
    set_in(2'd0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    #2;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Clear the array so every word has a known value
    for (int i = 0; i < 64; i++) begin
      set_in(2'd1, 1'b0, 3'd0, 32'(i * 4), 32'd0, 5'd0);
      step();
    end

    foreach (vecs[i]) begin
      set_in(vecs[i].mw, vecs[i].mr, vecs[i].lt, vecs[i].adr, vecs[i].wd, 5'(i + 1));
      step();
      check($sformatf("vec%0d.readdata", i), readdata_w, vecs[i].exp_rd);
      check($sformatf("vec%0d.misalign", i), {31'd0, misalign_w}, {31'd0, vecs[i].exp_mis});
      check($sformatf("vec%0d.regwrite", i), {31'd0, regwrite_w}, {31'd0, ~vecs[i].exp_mis});
      check($sformatf("vec%0d.aluout", i), aluout_w, vecs[i].adr);
      check_all($sformatf("vec%0d.model", i));
    end

    // Stall holds the captured load, stall with flush clears it
    set_in(2'd0, 1'b1, 3'd0, 32'd84, 32'd0, 5'd7);
    step();
    check("stall.pre", readdata_w, 32'h1234_565A);
    set_in(2'd0, 1'b1, 3'd0, 32'd80, 32'd0, 5'd9);
    stall_w = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      check($sformatf("stall%0d.readdata", c), readdata_w, 32'h1234_565A);
      check($sformatf("stall%0d.aluout", c), aluout_w, 32'd84);
      check($sformatf("stall%0d.writereg", c), {27'd0, writereg_w}, 32'd7);
    end
    flush_w = 1'b1;
    step();
    check_zero("stallflush");
    flush_w = 1'b0;
    stall_w = 1'b0;

    // Asynchronous reset between edges clears outputs, memory survives
    set_in(2'd0, 1'b1, 3'd0, 32'd80, 32'd0, 5'd3);
    step();
    check("prereset.readdata", readdata_w, 32'h0000_BEEF);
    #2;
    reset = 1'b1;
    #1;
    check_zero("asyncreset");
    e_rd = 32'd0; e_alu = 32'd0; e_rw = 1'b0; e_mtr = 1'b0; e_wr = 5'd0; e_mis = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    set_in(2'd0, 1'b1, 3'd0, 32'd80, 32'd0, 5'd3);
    step();
    check("postreset.readdata", readdata_w, 32'h0000_BEEF);

    // Random traffic against the byte-level model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] adr;
      adr = $urandom;
      if ($urandom_range(0, 1) == 0) adr[1:0] = 2'b00;
      memwrite   = 2'($urandom_range(0, 3));
      memread    = 1'($urandom_range(0, 1));
      loadtype   = 3'($urandom_range(0, 7));
      dataadr    = adr;
      writedata  = $urandom;
      regwrite_m = 1'($urandom_range(0, 1));
      memtoreg_m = 1'($urandom_range(0, 1));
      writereg_m = 5'($urandom_range(0, 31));
      stall_w    = ($urandom_range(0, 7) == 0);
      flush_w    = ($urandom_range(0, 9) == 0);
      step();
      check_all($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
